instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the pipelined processor, directly downstream of the UART-loaded instruction memory. It owns the program counter and drives the memory read address. It registers the returned 16-bit instruction into the IF/ID pipeline register with a valid bit. It also handles stall, branch redirect/flush, PC wrap-around and HALT detection.

## Interface
- `ADDR_W`, 4: PC / memory address width; memory depth is 2^ADDR_W.
- `INSN_W`, 16: instruction width.
- `HALT_INSN`, 16'hFFFF: instruction encoding that stops fetching.
- `clk` in 1: posedge clock; the memory writes on negedge, and its read is combinational.
- `reset` in 1: reset, synchronous, active-high.
- `exec_en` in 1: high while the memory is in execute mode (inverse of memory `read_mode`).
- `stall` in 1: hazard stall from decode; hold PC and IF/ID.
- `branch_taken` in 1: redirect request from a later stage.
- `branch_target` in ADDR_W: redirect address.
- `insn_in` in INSN_W: memory read data for `pc_addr`, valid in the same cycle.
- `pc_addr` out ADDR_W: current PC, drives memory `addr_in`.
- `if_id_insn` out INSN_W: registered instruction.
- `if_id_pc` out ADDR_W: PC of `if_id_insn`.
- `if_id_valid` out 1: IF/ID holds a real instruction; 0 means bubble.
- `halted` out 1: high in HALTED state.
- `fetch_count` out 8: number of instructions latched with valid=1, saturating at 255.

## Operation
- States:
  - IDLE: waiting for execute mode.
  - FETCH: normal fetch.
  - HALTED: HALT seen, fetching stopped.
- Per-edge priority: reset > !exec_en > branch_taken > stall > state action.
- reset: state is IDLE. PC, `if_id_insn`, `if_id_pc`, `if_id_valid` and `fetch_count` are all 0.
- !exec_en (any state): go to IDLE, PC 0, `if_id_valid` 0. `if_id_insn`/`if_id_pc` hold. `fetch_count` holds.
- IDLE with exec_en: go to FETCH with PC 0. No fetch on this edge, because memory output is only valid once in execute mode.
- branch_taken (FETCH or HALTED): PC takes `branch_target`, `if_id_valid` goes to 0, state goes to FETCH. A branch from an older in-flight instruction therefore cancels a HALT. Ignored in IDLE.
- stall (FETCH or HALTED): PC, IF/ID and state all hold.
- FETCH, normal:
  - `if_id_insn` takes `insn_in`, `if_id_pc` takes PC, `if_id_valid` goes to 1, `fetch_count` increments (saturating).
  - If `insn_in` == HALT_INSN: PC holds and state goes to HALTED.
  - Otherwise PC increments modulo 2^ADDR_W, so 15 wraps to 0.
- HALTED, normal: `if_id_valid` goes to 0, PC holds, count holds.
- PC arithmetic is ADDR_W bits unsigned; carry is discarded.

## Timing
- `pc_addr` to `insn_in` is combinational; IF/ID latency is 1 cycle.
- If exec_en is first sampled high at edge N, then:
  - at N+1, IF/ID holds address 0 with valid=1;
  - at N+k, IF/ID holds address k-1.
- Branch at edge M: exactly one bubble at M. Target instruction is in IF/ID at M+1.
- Stall asserted for S cycles delays the stream by S cycles. No instruction is lost or duplicated.
- Simultaneous branch_taken and stall: branch wins and the stall is dropped.
- HALT latched at edge H: `halted`=1 from H. `if_id_valid`=0 from H+1 unless stalled.
- Reset mid-run takes effect at the next edge. All outputs reach their reset values at that edge.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum (IDLE/FETCH/HALTED);
  - `HALT_INSN`;
  - the default `ADDR_W`/`INSN_W` constants, also used by decode.
- Single module, no sub-module. The next-PC mux and the IF/ID register are inline always blocks.

## Test plan
- Reset, then exec_en high with memory {0x1111, 0x2222, 0x3333, 0xFFFF} -> IF/ID sequence 0x1111@pc0, 0x2222@pc1, 0x3333@pc2, 0xFFFF@pc3. Then `halted`=1, `if_id_valid`=0, `fetch_count`=4.
- Program with no HALT, 20 cycles -> PC wraps 15→0, `if_id_pc` 15 is followed by 0, `fetch_count`=20.
- `stall` high for 3 cycles while IF/ID holds pc5 -> IF/ID stays pc5 and PC stays 6. After release the next entry is pc6.
- `branch_taken` with target 9 while fetching pc4 -> one cycle `if_id_valid`=0, then IF/ID holds pc9. Branch with stall together gives the same result.
- HALT latched, then `branch_taken` target 2 -> `halted` goes low, IF/ID holds pc2 after one bubble.
- `reset` asserted mid-run at pc7 -> next edge: state IDLE, all outputs 0. Re-enabling restarts at pc0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: state encoding, HALT encoding and default widths.
// Decode reuses the width constants so both stages agree on the IF/ID layout.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 4;
  localparam int unsigned FETCH_INSN_W = 16;
  localparam logic [FETCH_INSN_W-1:0] HALT_INSN = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address and registers
// the returned instruction into IF/ID; handles stall, branch redirect and HALT.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = FETCH_ADDR_W,
  parameter int unsigned INSN_W = FETCH_INSN_W,
  parameter logic [INSN_W-1:0] HALT_INSN = fetch_pkg::HALT_INSN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exec_en,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [INSN_W-1:0] insn_in,
  output logic [ADDR_W-1:0] pc_addr,
  output logic [INSN_W-1:0] if_id_insn,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic              if_id_valid,
  output logic              halted,
  output logic [7:0]        fetch_count,
  output fetch_state_e      state_dbg
);

  // Handshake: there is no valid/ready pair here; `stall` is a hold request
  // from decode and freezes PC, IF/ID and state on the edge it is sampled.

  fetch_state_e      state_q, state_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic [INSN_W-1:0] insn_q, insn_n;
  logic [ADDR_W-1:0] ifpc_q, ifpc_n;
  logic              valid_q, valid_n;
  logic [7:0]        count_q, count_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      insn_q  <= '0;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      insn_q  <= insn_n;
      ifpc_q  <= ifpc_n;
      valid_q <= valid_n;
      count_q <= count_n;
    end
  end

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    insn_n  = insn_q;
    ifpc_n  = ifpc_q;
    valid_n = valid_q;
    count_n = count_q;

    if (!exec_en) begin
      // Leaving execute mode drops the pipeline entry but keeps its contents.
      state_n = ST_IDLE;
      pc_n    = '0;
      valid_n = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Memory read data is not trustworthy until one edge into execute mode.
          state_n = ST_FETCH;
          pc_n    = '0;
        end
        ST_FETCH, ST_HALTED: begin
          if (branch_taken) begin
            state_n = ST_FETCH;
            pc_n    = branch_target;
            valid_n = 1'b0;
          end else if (!stall) begin
            if (state_q == ST_FETCH) begin
              insn_n  = insn_in;
              ifpc_n  = pc_q;
              valid_n = 1'b1;
              count_n = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
              if (insn_in == HALT_INSN) state_n = ST_HALTED;
              else                      pc_n    = pc_q + 1'b1;
            end else begin
              valid_n = 1'b0;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          pc_n    = '0;
          valid_n = 1'b0;
        end
      endcase
    end
  end

  assign pc_addr     = pc_q;
  assign if_id_insn  = insn_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == ST_HALTED);
  assign fetch_count = count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, hand-written
// wrap/stall/branch/reset/saturation sequences and a randomized model comparison.
module tb_instruction_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exec_en = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [3:0]  branch_target = '0;
  logic [15:0] insn_in;
  logic [3:0]  pc_addr;
  logic [15:0] if_id_insn;
  logic [3:0]  if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic [7:0]  fetch_count;
  fetch_state_e state_dbg;

  logic [15:0] mem [16];
  assign insn_in = mem[pc_addr];

  int total = 0;
  int bad = 0;

  // clock / reset block
  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .exec_en(exec_en), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .insn_in(insn_in), .pc_addr(pc_addr), .if_id_insn(if_id_insn),
    .if_id_pc(if_id_pc), .if_id_valid(if_id_valid), .halted(halted),
    .fetch_count(fetch_count), .state_dbg(state_dbg)
  );

  // behavioural reference model, stepped once per clock edge
  int          m_mode;   // 0 waiting, 1 running, 2 halted
  int          m_pc;
  logic [15:0] m_insn;
  int          m_ifpc;
  logic        m_valid;
  int          m_cnt;

  task automatic model_edge(input logic r, input logic en, input logic st,
                            input logic br, input int tgt);
    if (r) begin
      m_mode = 0; m_pc = 0; m_insn = 0; m_ifpc = 0; m_valid = 0; m_cnt = 0;
    end else if (!en) begin
      m_mode = 0; m_pc = 0; m_valid = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_pc = 0;
    end else if (br) begin
      m_pc = tgt; m_valid = 0; m_mode = 1;
    end else if (st) begin
      // everything holds
    end else if (m_mode == 1) begin
      m_insn = mem[m_pc]; m_ifpc = m_pc; m_valid = 1;
      if (m_cnt < 255) m_cnt = m_cnt + 1;
      if (m_insn == 16'hFFFF) m_mode = 2;
      else m_pc = (m_pc + 1) % 16;
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},    32'(pc_addr),     32'(m_pc));
    check({tag, ".insn"},  32'(if_id_insn),  32'(m_insn));
    check({tag, ".ifpc"},  32'(if_id_pc),    32'(m_ifpc));
    check({tag, ".valid"}, 32'(if_id_valid), 32'(m_valid));
    check({tag, ".halt"},  32'(halted),      32'(m_mode == 2));
    check({tag, ".cnt"},   32'(fetch_count), 32'(m_cnt));
  endtask

  // driver: apply inputs after the falling edge, let one rising edge pass, settle
  task automatic drive(input logic r, input logic en, input logic st,
                       input logic br, input logic [3:0] tgt);
    @(negedge clk);
    reset = r; exec_en = en; stall = st; branch_taken = br; branch_target = tgt;
    model_edge(r, en, st, br, int'(tgt));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r, en, st, br;
    logic [3:0]  tgt;
    logic [3:0]  e_pc;
    logic [15:0] e_insn;
    logic [3:0]  e_ifpc;
    logic        e_valid, e_halt;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic r, input logic en, input logic st,
                              input logic br, input logic [3:0] tgt, input logic [3:0] pc,
                              input logic [15:0] insn, input logic [3:0] ifpc,
                              input logic v, input logic h, input logic [7:0] c);
    vec_t x;
    x.r = r; x.en = en; x.st = st; x.br = br; x.tgt = tgt;
    x.e_pc = pc; x.e_insn = insn; x.e_ifpc = ifpc; x.e_valid = v; x.e_halt = h; x.e_cnt = c;
    return x;
  endfunction

  task automatic fill_plain();
    for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
  endtask

  initial begin
    fill_plain();
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'hFFFF;
    //            r  en st br tgt   pc  insn      ifpc v  h  cnt
    vecs[0]  = mk(1, 0, 0, 0, 0,    0,  16'h0000, 0,   0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 0,    0,  16'h0000, 0,   0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 0,    1,  16'h1111, 0,   1, 0, 1);
    vecs[3]  = mk(0, 1, 0, 0, 0,    2,  16'h2222, 1,   1, 0, 2);
    vecs[4]  = mk(0, 1, 0, 0, 0,    3,  16'h3333, 2,   1, 0, 3);
    vecs[5]  = mk(0, 1, 0, 0, 0,    3,  16'hFFFF, 3,   1, 1, 4);
    vecs[6]  = mk(0, 1, 0, 0, 0,    3,  16'hFFFF, 3,   0, 1, 4);
    vecs[7]  = mk(0, 1, 0, 1, 2,    2,  16'hFFFF, 3,   0, 0, 4);
    vecs[8]  = mk(0, 1, 0, 0, 0,    3,  16'h3333, 2,   1, 0, 5);
    vecs[9]  = mk(0, 1, 1, 1, 9,    9,  16'h3333, 2,   0, 0, 5);
    vecs[10] = mk(0, 1, 0, 0, 0,    10, 16'h1009, 9,   1, 0, 6);
    vecs[11] = mk(0, 1, 1, 0, 0,    10, 16'h1009, 9,   1, 0, 6);
    vecs[12] = mk(0, 1, 1, 0, 0,    10, 16'h1009, 9,   1, 0, 6);
    vecs[13] = mk(0, 1, 0, 0, 0,    11, 16'h100A, 10,  1, 0, 7);
    vecs[14] = mk(0, 0, 0, 0, 0,    0,  16'h100A, 10,  0, 0, 7);
    vecs[15] = mk(1, 0, 0, 0, 0,    0,  16'h0000, 0,   0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].r, vecs[i].en, vecs[i].st, vecs[i].br, vecs[i].tgt);
      check($sformatf("vec%0d.pc", i),    32'(pc_addr),     32'(vecs[i].e_pc));
      check($sformatf("vec%0d.insn", i),  32'(if_id_insn),  32'(vecs[i].e_insn));
      check($sformatf("vec%0d.ifpc", i),  32'(if_id_pc),    32'(vecs[i].e_ifpc));
      check($sformatf("vec%0d.valid", i), 32'(if_id_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d.halt", i),  32'(halted),      32'(vecs[i].e_halt));
      check($sformatf("vec%0d.cnt", i),   32'(fetch_count), 32'(vecs[i].e_cnt));
    end
    check("reset.state", 32'(state_dbg), 32'(ST_IDLE));

    // wrap-around: 20 fetches with no HALT in memory
    fill_plain();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      drive(0, 1, 0, 0, 0);
      check("wrap.ifpc", 32'(if_id_pc), 32'((k - 1) % 16));
      check("wrap.insn", 32'(if_id_insn), 32'(16'h1000 + 16'((k - 1) % 16)));
      check("wrap.valid", 32'(if_id_valid), 32'd1);
    end
    check("wrap.cnt", 32'(fetch_count), 32'd20);

    // stall for 3 cycles while IF/ID holds pc5
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) drive(0, 1, 0, 0, 0);
    check("stall.pre", 32'(if_id_pc), 32'd5);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 0, 0);
      check("stall.ifpc", 32'(if_id_pc), 32'd5);
      check("stall.pc", 32'(pc_addr), 32'd6);
    end
    drive(0, 1, 0, 0, 0);
    check("stall.next", 32'(if_id_pc), 32'd6);
    check("stall.cnt", 32'(fetch_count), 32'd7);

    // branch while fetching pc4, then reset mid-run at pc7
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) drive(0, 1, 0, 0, 0);
    check("br.fetching", 32'(pc_addr), 32'd4);
    drive(0, 1, 0, 1, 9);
    check("br.bubble", 32'(if_id_valid), 32'd0);
    drive(0, 1, 0, 0, 0);
    check("br.ifpc", 32'(if_id_pc), 32'd9);
    check("br.valid", 32'(if_id_valid), 32'd1);
    drive(0, 1, 0, 1, 7);
    check("rst.atpc7", 32'(pc_addr), 32'd7);
    drive(1, 1, 0, 0, 0);
    check("rst.pc", 32'(pc_addr), 32'd0);
    check("rst.valid", 32'(if_id_valid), 32'd0);
    check("rst.ifpc", 32'(if_id_pc), 32'd0);
    check("rst.cnt", 32'(fetch_count), 32'd0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    check("restart.ifpc", 32'(if_id_pc), 32'd0);
    check("restart.valid", 32'(if_id_valid), 32'd1);

    // saturation of fetch_count
    for (int k = 0; k < 260; k++) drive(0, 1, 0, 0, 0);
    check("sat.cnt", 32'(fetch_count), 32'd255);

    // randomized run against the reference model
    drive(1, 0, 0, 0, 0);
    check_model("rnd.rst");
    for (int n = 0; n < 800; n++) begin
      logic r, en, st, br;
      if ($urandom_range(0, 31) == 0)
        mem[$urandom_range(0, 15)] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      r  = ($urandom_range(0, 99) < 2);
      en = ($urandom_range(0, 99) < 93);
      st = ($urandom_range(0, 99) < 20);
      br = ($urandom_range(0, 99) < 10);
      drive(r, en, st, br, 4'($urandom_range(0, 15)));
      check_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, total=%0d", total);
    $fatal(1);
  end

endmodule
